// File: rtl/inv_mix_columns_seq.sv
// inv_mix_columns_seq
//   Applies AES InvMixColumns to a 128-bit state one column per cycle through
//   a single shared column helper. The final decryption round sets a bypass
//   flag with its request, and the state then passes through unchanged.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      synchronous active-low reset
//   i_in_valid   request strobe
//   o_in_ready   high only in IDLE
//   i_in_bypass  sampled with the request; 1 = pass state through
//   i_in_state   column 0 = [127:96], column 3 = [31:0], byte 0 in column MSBs
//   o_out_valid  result available (DONE)
//   i_out_ready  downstream accepts result
//   o_out_state  result state, always driven from the state register
//   o_busy       high whenever the FSM is not IDLE
module inv_mix_columns_seq (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic         i_in_bypass,
  input  logic [127:0] i_in_state,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_out_state,
  output logic         o_busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_fsm;
  logic [1:0]      r_col;
  // Packed view: r_st[3] is column 0 (the MSBs), r_st[0] is column 3.
  logic [3:0][31:0] r_st;
  logic            r_in_ready;
  logic            r_out_valid;
  logic            r_busy;

  logic [31:0]     w_col_in;
  logic [31:0]     w_col_out;
  logic [1:0]      w_idx;

  // Multiply by x in GF(2^8) mod 0x11B.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  // Column col lives at packed index 3-col.
  assign w_idx    = 2'd3 - r_col;
  assign w_col_in = r_st[w_idx];

  // Shared column helper.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    a0 = w_col_in[31:24];
    a1 = w_col_in[23:16];
    a2 = w_col_in[15:8];
    a3 = w_col_in[7:0];
    w_col_out = {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                 mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                 muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                 mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fsm       <= IDLE;
      r_col       <= 2'd0;
      r_st        <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (i_in_valid) begin
            r_st       <= i_in_state;
            r_col      <= 2'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (i_in_bypass) begin
              r_fsm       <= DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_fsm <= RUN;
            end
          end
        end
        RUN: begin
          r_st[w_idx] <= w_col_out;
          r_col       <= r_col + 2'd1;   // wraps to 0 after column 3
          if (r_col == 2'd3) begin
            r_fsm       <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_fsm       <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_fsm       <= IDLE;
          r_col       <= 2'd0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_out_state = r_st;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_bypass;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [127:0] sb_q[$];

  inv_mix_columns_seq dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_bypass(in_bypass),
    .i_in_state (in_state),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_out_state(out_state),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Plain shift-and-add GF(2^8) multiply, reduction by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h11b << (i - 8));
    return p[7:0];
  endfunction

  // Multiply every column by a circulant matrix whose first row is r.
  function automatic logic [127:0] matmix(input logic [127:0] s, input logic [31:0] r);
    logic [7:0] row[4];
    logic [7:0] c[4];
    logic [7:0] o;
    logic [127:0] res = '0;
    for (int k = 0; k < 4; k++) row[k] = r[31-8*k -: 8];
    for (int cl = 0; cl < 4; cl++) begin
      for (int k = 0; k < 4; k++) c[k] = s[127-32*cl-8*k -: 8];
      for (int i = 0; i < 4; i++) begin
        o = 8'h0;
        for (int j = 0; j < 4; j++) o = o ^ gmul(row[(j - i + 4) % 4], c[j]);
        res[127-32*cl-8*i -: 8] = o;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] fwd_mix(input logic [127:0] s);
    return matmix(s, 32'h02030101);
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    return matmix(s, 32'h0e0b0d09);
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  // Values at the falling edge are what the next rising edge will see.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_output got=%h expected=none", out_state);
      end else begin
        chk("scoreboard", out_state, sb_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  int last_accept;

  task automatic send(input logic [127:0] st, input logic byp, input logic [127:0] exp);
    int n = 0;
    in_state  = st;
    in_bypass = byp;
    in_valid  = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout got=in_ready=0 expected=1");
      in_valid = 1'b0;
      return;
    end
    sb_q.push_back(exp);
    @(posedge clk);
    last_accept = cyc;
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Edges after the accept edge until out_valid is seen (0 = already valid).
  task automatic measure_lat(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  logic [127:0] vec_in  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  logic [127:0] vec_out = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  logic [127:0] byp_vec = 128'h0123456789abcdeffedcba9876543210;

  initial begin
    int lat, a0, a1, a2, n;
    logic stable, seen;
    logic [127:0] snap, x, s;
    logic b;
    logic rnd_done;

    rst_n = 1'b0; in_valid = 1'b0; in_bypass = 1'b0; in_state = '0; out_ready = 1'b0;
    wait_edges(3);
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_out_state", out_state, 128'd0);
    rst_n = 1'b1;
    wait_edges(1);

    // sanity of the model itself against the known vector
    chk("model_vector", inv_mix(vec_in), vec_out);

    // Known vector with junk requests offered during RUN and DONE.
    send(vec_in, 1'b0, vec_out);
    in_valid = 1'b1; in_state = ~vec_in; in_bypass = 1'b1;
    measure_lat(lat);
    chk("normal_latency", 128'(lat), 128'd4);
    snap = out_state; stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_state !== snap || !out_valid || in_ready) stable = 1'b0;
    end
    chk("backpressure_stable", 128'(stable), 128'd1);
    chk("backpressure_in_ready", 128'(in_ready), 128'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;          // handshake edge
    chk("in_ready_after_hs", 128'(in_ready), 128'd1);
    chk("out_valid_after_hs", 128'(out_valid), 128'd0);
    out_ready = 1'b0;

    // Bypass
    send(byp_vec, 1'b1, byp_vec);
    measure_lat(lat);
    chk("bypass_latency", 128'(lat), 128'd0);
    chk("bypass_state", out_state, byp_vec);
    out_ready = 1'b1;
    wait_edges(2);

    // Back-to-back normal requests, out_ready high.
    x = {$urandom, $urandom, $urandom, $urandom};
    send(x, 1'b0, inv_mix(x)); a0 = last_accept;
    x = {$urandom, $urandom, $urandom, $urandom};
    send(x, 1'b0, inv_mix(x)); a1 = last_accept;
    x = {$urandom, $urandom, $urandom, $urandom};
    send(x, 1'b0, inv_mix(x)); a2 = last_accept;
    chk("spacing_1", 128'(a1 - a0), 128'd6);
    chk("spacing_2", 128'(a2 - a1), 128'd6);
    wait_edges(8);

    // Reset after column 1 written (edge E2).
    x = {$urandom, $urandom, $urandom, $urandom};
    send(x, 1'b0, inv_mix(x));
    wait_edges(2);
    rst_n = 1'b0;
    sb_q.delete();
    wait_edges(1);
    rst_n = 1'b1;
    chk("rst_mid_in_ready", 128'(in_ready), 128'd1);
    chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
    chk("rst_mid_out_state", out_state, 128'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("no_stale_valid", 128'(seen), 128'd0);
    x = {$urandom, $urandom, $urandom, $urandom};
    send(x, 1'b0, inv_mix(x));
    wait_edges(8);

    // Round trip: forward MixColumns in the model, inverse in the DUT.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          x = {$urandom, $urandom, $urandom, $urandom};
          b = 1'($urandom_range(0, 3) == 0);
          s = b ? x : fwd_mix(x);
          send(s, b, x);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk); n++;
    end
    chk("drain_empty", 128'(sb_q.size()), 128'd0);
    wait_edges(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
